// File: rtl/bp_me_stream_beat_tracker.sv
// Beat tracker for one BedRock header+data stream.
//
// From the header type, size and address presented with each beat, this block
// derives how many data beats the message spans. It counts the beats that have
// transferred and reports the current beat index, first/last markers and a
// critical-word-first address that wraps inside the size-aligned block.
//
// The only state is the beat counter cnt_r. The two phases below are decoded
// from it rather than held in a separate state register.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE/FIRST | cnt_r == 0: idle, or beat 0 of a message is on the bus
//   MID        | cnt_r != 0: beats 1..beats-1 of a message are in flight
module bp_me_stream_beat_tracker #(
    parameter int data_width_p     = 64,
    parameter int msg_type_width_p = 4,
    parameter int size_width_p     = 3,
    parameter int addr_width_p     = 40,
    parameter logic [(1<<msg_type_width_p)-1:0] payload_mask_p = 'h2A,
    localparam int cnt_width_p =
        ($clog2(1024/data_width_p) > 1) ? $clog2(1024/data_width_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [msg_type_width_p-1:0] msg_type_i,
    input  logic [size_width_p-1:0]     size_i,
    input  logic [addr_width_p-1:0]     addr_i,
    input  logic                        v_i,
    input  logic                        ready_and_i,
    output logic [cnt_width_p-1:0]      cnt_o,
    output logic                        first_o,
    output logic                        last_o,
    output logic [addr_width_p-1:0]     addr_o,
    output logic                        has_payload_o
);

    // log2 of the beat width in bits and in bytes
    localparam int lg_dw_lp = $clog2(data_width_p);
    localparam int lg_bb_lp = lg_dw_lp - 3;

    logic [cnt_width_p-1:0]  cnt_r;
    logic [cnt_width_p-1:0]  cnt_n;
    logic [cnt_width_p-1:0]  beats_m1;
    logic [addr_width_p-1:0] blk_mask;
    logic [addr_width_p-1:0] beat_off;
    logic [addr_width_p-1:0] wrap_sum;

    assign has_payload_o = payload_mask_p[msg_type_i];

    // Final beat index: a payload message spans msg_bits/data_width beats,
    // everything else (and anything smaller than one beat) is a single beat.
    always_comb begin
        beats_m1 = '0;
        if (has_payload_o && ((int'(size_i) + 3) > lg_dw_lp)) begin
            beats_m1 = cnt_width_p'((1 << (int'(size_i) + 3 - lg_dw_lp)) - 1);
        end
    end

    // Next beat index; a counter already past the final beat (header changed
    // mid-message) is pulled back to 0 on the next transfer.
    always_comb begin
        cnt_n = cnt_r;
        if (v_i && ready_and_i) begin
            if (cnt_r >= beats_m1) begin
                cnt_n = '0;
            end else begin
                cnt_n = cnt_r + 1'b1;
            end
        end
    end

    // Beat counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

    assign cnt_o   = cnt_r;
    assign first_o = (cnt_r == '0);
    assign last_o  = (cnt_r == beats_m1);

    // Wrapped beat address: the low size_i bits advance by one beat per count
    // and wrap; the bits above the block are taken from the header as-is.
    always_comb begin
        blk_mask = ({{(addr_width_p-1){1'b0}}, 1'b1} << size_i) - 1'b1;
        beat_off = addr_width_p'(cnt_r) << lg_bb_lp;
        wrap_sum = addr_i + beat_off;
        if (beats_m1 == '0) begin
            addr_o = addr_i;
        end else begin
            addr_o = (addr_i & ~blk_mask) | (wrap_sum & blk_mask);
        end
    end

endmodule

// File: tb/tb_bp_me_stream_beat_tracker.sv
// Scoreboard bench for bp_me_stream_beat_tracker (64-bit beats, mask 0x2A).
// The driver applies one cycle of stimulus at a time, predicts the outputs for
// that cycle from a message-level model and queues them; a monitor on the
// falling edge pops each prediction and compares it with the DUT.
module tb_bp_me_stream_beat_tracker;

    localparam int DW = 64;
    localparam logic [15:0] MASK = 16'h002A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  msg_type = '0;
    logic [2:0]  size = '0;
    logic [39:0] addr = '0;
    logic        v = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  cnt;
    logic        first;
    logic        last;
    logic [39:0] addr_out;
    logic        has_payload;

    always #5 clk = ~clk;

    bp_me_stream_beat_tracker #(
        .data_width_p(DW), .msg_type_width_p(4), .size_width_p(3),
        .addr_width_p(40), .payload_mask_p(MASK)
    ) dut (
        .clk_i(clk), .reset_i(reset), .msg_type_i(msg_type), .size_i(size),
        .addr_i(addr), .v_i(v), .ready_and_i(ready), .cnt_o(cnt),
        .first_o(first), .last_o(last), .addr_o(addr_out),
        .has_payload_o(has_payload)
    );

    typedef struct {
        logic [3:0]  cnt;
        logic        first;
        logic        last;
        logic        hp;
        logic [39:0] addr;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mcnt = 0;   // model: beats already transferred in the current message

    // Apply one cycle of stimulus, queue the predicted outputs, advance the model
    task automatic cyc(input logic [3:0] t, input logic [2:0] s,
                       input logic [39:0] a, input logic vv, input logic rr,
                       input logic rst);
        exp_t        e;
        int          mb;
        int          beats;
        logic [39:0] m;
        @(posedge clk);
        #1;
        msg_type = t; size = s; addr = a; v = vv; ready = rr; reset = rst;
        mb = 1 << s;
        beats = 1;
        if (MASK[t] && (mb * 8 / DW) > 1) beats = mb * 8 / DW;
        m = 40'(mb - 1);
        e.cnt   = 4'(mcnt);
        e.first = (mcnt == 0);
        e.last  = (mcnt == beats - 1);
        e.hp    = MASK[t];
        if (beats == 1) e.addr = a;
        else e.addr = (a & ~m) | (((a & m) + 40'(mcnt * (DW / 8))) & m);
        q.push_back(e);
        if (rst) mcnt = 0;
        else if (vv && rr) mcnt = (mcnt >= beats - 1) ? 0 : mcnt + 1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued prediction
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            bit   bad;
            e = q.pop_front();
            vectors++;
            bad = 0;
            if (cnt !== e.cnt) begin
                $display("FAIL cnt: got %0d expected %0d at %0t", cnt, e.cnt, $time); bad = 1;
            end
            if (first !== e.first) begin
                $display("FAIL first: got %b expected %b at %0t", first, e.first, $time); bad = 1;
            end
            if (last !== e.last) begin
                $display("FAIL last: got %b expected %b at %0t", last, e.last, $time); bad = 1;
            end
            if (has_payload !== e.hp) begin
                $display("FAIL has_payload: got %b expected %b at %0t", has_payload, e.hp, $time); bad = 1;
            end
            if (addr_out !== e.addr) begin
                $display("FAIL addr: got %h expected %h at %0t", addr_out, e.addr, $time); bad = 1;
            end
            if (bad) miscompares++;
        end
    end

    // Hand-derived checks for the 64 B wrap example, sampled alongside the model
    logic [39:0] wrap_tab [8] = '{40'h1028, 40'h1030, 40'h1038, 40'h1000,
                                  40'h1008, 40'h1010, 40'h1018, 40'h1020};

    initial begin
        logic [39:0] ra;
        logic [3:0]  rt;
        logic [2:0]  rs;
        int          nb;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        mcnt = 0;

        // Reset state, idle
        cyc(4'd1, 3'd6, 40'h1028, 1'b0, 1'b0, 1'b0);

        // Multi-beat wrap: 8 back-to-back beats, then back to beat 0
        for (int i = 0; i < 8; i++) begin
            cyc(4'd1, 3'd6, 40'h1028, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            #1;
            vectors++;
            if (addr_out !== wrap_tab[i]) begin
                $display("FAIL wrap_addr beat %0d: got %h expected %h", i, addr_out, wrap_tab[i]);
                miscompares++;
            end
        end
        cyc(4'd1, 3'd6, 40'h1028, 1'b0, 1'b0, 1'b0);

        // No-payload read of a 64 B size
        cyc(4'd0, 3'd6, 40'h2000, 1'b1, 1'b1, 1'b0);
        cyc(4'd0, 3'd6, 40'h2000, 1'b0, 1'b0, 1'b0);

        // Stalls on beat 0 of a 2-beat uncached write
        cyc(4'd3, 3'd4, 40'h4010, 1'b1, 1'b0, 1'b0);
        cyc(4'd3, 3'd4, 40'h4010, 1'b0, 1'b1, 1'b0);
        cyc(4'd3, 3'd4, 40'h4010, 1'b1, 1'b0, 1'b0);
        cyc(4'd3, 3'd4, 40'h4010, 1'b1, 1'b1, 1'b0);
        cyc(4'd3, 3'd4, 40'h4010, 1'b1, 1'b1, 1'b0);

        // Sub-beat uncached write
        cyc(4'd3, 3'd2, 40'h3004, 1'b1, 1'b1, 1'b0);

        // Reset after 3 beats, then a full 8-beat message
        for (int i = 0; i < 3; i++) cyc(4'd1, 3'd6, 40'h5000, 1'b1, 1'b1, 1'b0);
        cyc(4'd1, 3'd6, 40'h5000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(4'd1, 3'd6, 40'h5018, 1'b1, 1'b1, 1'b0);

        // Back-to-back: 2-beat write then 1-beat read
        cyc(4'd1, 3'd4, 40'h6000, 1'b1, 1'b1, 1'b0);
        cyc(4'd1, 3'd4, 40'h6000, 1'b1, 1'b1, 1'b0);
        cyc(4'd0, 3'd4, 40'h6100, 1'b1, 1'b1, 1'b0);

        // Size shrinks mid-message: counter beyond the new last beat recovers
        for (int i = 0; i < 5; i++) cyc(4'd5, 3'd6, 40'h7000, 1'b1, 1'b1, 1'b0);
        cyc(4'd5, 3'd4, 40'h7000, 1'b0, 1'b0, 1'b0);
        cyc(4'd5, 3'd4, 40'h7000, 1'b1, 1'b1, 1'b0);
        cyc(4'd5, 3'd4, 40'h7000, 1'b1, 1'b1, 1'b0);

        // Random messages with random stalls and occasional resets
        for (int m = 0; m < 120; m++) begin
            rt = 4'($urandom_range(0, 15));
            rs = 3'($urandom_range(0, 7));
            ra = {8'($urandom), 32'($urandom)};
            nb = 1;
            if (MASK[rt] && ((1 << rs) * 8 / DW) > 1) nb = (1 << rs) * 8 / DW;
            for (int b = 0; b < nb; b++) begin
                logic vv, rr, rst;
                int   guard;
                guard = 0;
                do begin
                    vv  = 1'($urandom_range(0, 3) != 0);
                    rr  = 1'($urandom_range(0, 3) != 0);
                    rst = ($urandom_range(0, 99) == 0);
                    cyc(rt, rs, ra, vv, rr, rst);
                    guard++;
                end while (!(vv && rr) && !rst && guard < 50);
                if (rst) break;
            end
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_me_stream_beat_tracker.md
# bp_me_stream_beat_tracker

Parametrised beat tracker for BedRock streamed messages. It monitors one header+data stream, which may be a mem_cmd, mem_resp or LCE channel. From the message type, a per-channel payload mask and the message size, it derives how many data beats the message occupies. It tracks the current beat index and produces first/last markers and a per-beat wrapped address. It replaces the per-channel hand-coded beat counters in the ME stream pumps with one block that is selected per channel by `payload_mask_p`.

## Interface
Parameters:
- `data_width_p`, 64: bits per data beat. Power of two, 8..1024.
- `msg_type_width_p`, 4: width of the header message-type field.
- `size_width_p`, 3: width of the size field, BedRock encoding (0 = 1 B … 7 = 128 B).
- `addr_width_p`, 40: width of the header address.
- `payload_mask_p`, `mem_cmd_payload_mask_gp`: bit i set means message type i carries a multi-beat payload.
- `cnt_width_p`, derived `max(1, $clog2(1024/data_width_p))`: beat-index width. Not overridable.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: synchronous, active-high reset.
- `msg_type_i` in `msg_type_width_p`: header message type. Held stable for all beats of a message.
- `size_i` in `size_width_p`: header message size. Held stable for the message.
- `addr_i` in `addr_width_p`: header base address. Held stable for the message.
- `v_i` in 1: stream valid (observed).
- `ready_and_i` in 1: stream ready (observed). A beat transfers when `v_i & ready_and_i`.
- `cnt_o` out `cnt_width_p`: index of the current beat.
- `first_o` out 1: current beat is beat 0.
- `last_o` out 1: current beat is the final beat.
- `addr_o` out `addr_width_p`: byte address of the current beat.
- `has_payload_o` out 1: `payload_mask_p[msg_type_i]`.

## Operation
- **Beat count**
  - `msg_bytes = 1 << size_i`.
  - With payload: `beats = max(1, msg_bytes*8/data_width_p)`.
  - Without payload: `beats = 1`, regardless of size.
- **State**: one register, `cnt_r`. States are IDLE/FIRST (`cnt_r == 0`) and MID (`cnt_r != 0`).
- **Handshake with `last_o == 0`**: `cnt_r <= cnt_r + 1`.
- **Handshake with `last_o == 1`**: `cnt_r <= 0`. The next message starts the following cycle.
- **No handshake**: `cnt_r` holds. This covers `v_i` without `ready_and_i`, `ready_and_i` without `v_i`, and idle.
- **Outputs**
  - `cnt_o = cnt_r`.
  - `first_o = (cnt_r == 0)`.
  - `last_o = (cnt_r == beats-1)`.
  - `first_o` and `last_o` are both 1 for single-beat messages.
- **Address**
  - `beat_bytes = data_width_p/8`.
  - Let `off = addr_i[size_i-1:0] + cnt_r*beat_bytes`, taken mod `msg_bytes`.
  - `addr_o = {addr_i` bits at and above `size_i`, `off}`. This gives critical-word-first wrap within the size-aligned block.
  - Single-beat messages: `addr_o = addr_i`.
- **Width rules**
  - `cnt_r*beat_bytes` is computed at `addr_width_p` width; overflow is discarded by the mod.
  - If `msg_bytes < beat_bytes`, `beats = 1` and there is no wrap.
- **Boundary conditions**
  - Message type or size changing mid-message is a protocol violation. Behaviour is unspecified except that `cnt_r` must stay at or below its maximum value: if `cnt_r > beats-1`, the next handshake forces `cnt_r <= 0`.
  - Reset during a message: `cnt_r` becomes 0 on the next edge. Any partial message is abandoned.

## Timing
- All outputs are combinational from `cnt_r` and the header inputs. Zero latency: the outputs describe the beat currently presented on the stream.
- `cnt_r` updates on the rising edge of `clk_i` following a handshake.
- **Reset values**
  - `cnt_r = 0`, so `cnt_o = 0` and `first_o = 1`.
  - `last_o`, `addr_o` and `has_payload_o` follow the inputs (`addr_o = addr_i` in beat 0).
- Back-to-back messages are supported: a last-beat handshake in cycle N lets beat 0 of the next message transfer in cycle N+1.
- No bubbles are inserted; the block never drives ready.

## Test plan
All scenarios use `data_width_p=64` and the default mask (0x2A: wr=1, uc_wr=3, amo=5).
- **Multi-beat wrap**: `e_bedrock_mem_wr`, size 6 (64 B), addr 0x1028, 8 consecutive handshakes -> `addr_o` sequence is 0x1028, 0x1030, 0x1038, 0x1000, 0x1008, 0x1010, 0x1018, 0x1020. `last_o` is high only on beat 7, then `cnt_o` returns to 0.
- **No-payload type**: `e_bedrock_mem_rd`, size 6, addr 0x2000 -> `has_payload_o=0`, `first_o=last_o=1` on a single handshake, and `cnt_o` stays 0.
- **Stalls**: `e_bedrock_mem_uc_wr`, size 4 (2 beats); beat 0 presented with `ready_and_i=0` for 3 cycles -> `cnt_o` holds at 0. Handshake -> `cnt_o=1` and `last_o=1`.
- **Sub-beat size**: `e_bedrock_mem_uc_wr`, size 2 (4 B), addr 0x3004 -> 1 beat, `last_o=1`, `addr_o=0x3004`.
- **Reset mid-message**: `e_bedrock_mem_wr`, size 6; assert `reset_i` after 3 handshakes -> next cycle `cnt_o=0`, `first_o=1`. A new 8-beat message then completes normally.
- **Back-to-back**: a 2-beat write immediately followed by a 1-beat read, with `v_i` and `ready_and_i` high throughout -> `cnt_o` sequence is 0, 1, 0, and `last_o` is high in cycles 2 and 3.
